// File: rtl/regfile_mp_if.sv
// Port bundle for regfile_mp: read/write address and data buses plus status flags.
// The master drives addresses and writes; the slave (the register file) returns data and status.
interface regfile_mp_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int NWR   = 1
);
  localparam int AW = $clog2(NREGS);

  logic [NRD*AW-1:0]   raddr;
  logic [NRD*XLEN-1:0] rdata;
  logic [NWR-1:0]      we;
  logic [NWR*AW-1:0]   waddr;
  logic [NWR*XLEN-1:0] wdata;
  logic                busy;
  logic                wr_conflict;

  modport master (
    output raddr, we, waddr, wdata,
    input  rdata, busy, wr_conflict
  );

  modport slave (
    input  raddr, we, waddr, wdata,
    output rdata, busy, wr_conflict
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file: NRD async read ports, NWR sync write ports, sequential clear after reset.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter int ZERO_REG = 1
) (
  input  logic         clk,
  input  logic         reset,
  regfile_mp_if.slave  bus
);
  localparam int AW = $clog2(NREGS);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   clr_idx_q, clr_idx_d;
  logic            wr_conflict_q, wr_conflict_d;
  logic            collide;

  logic [XLEN-1:0] mem [NREGS];

  logic [NWR-1:0]  wr_en;
  logic [AW-1:0]   waddr_w [NWR];
  logic [XLEN-1:0] wdata_w [NWR];

  // wr_en already folds in reset, state and the hardwired-zero drop, so it means "this write commits".
  for (genvar gi = 0; gi < NWR; gi++) begin : g_wr
    assign waddr_w[gi] = bus.waddr[gi*AW +: AW];
    assign wdata_w[gi] = bus.wdata[gi*XLEN +: XLEN];
    assign wr_en[gi]   = (state_q == READY) && !reset && bus.we[gi]
                         && !((ZERO_REG != 0) && (waddr_w[gi] == '0));
  end

  // Collisions are flagged on the raw enables, so a dropped write to entry 0 still counts.
  if (NWR >= 2) begin : g_coll
    assign collide = (state_q == READY) && bus.we[0] && bus.we[1]
                     && (waddr_w[0] == waddr_w[1]);
  end else begin : g_no_coll
    assign collide = 1'b0;
  end

  always_comb begin
    state_d       = state_q;
    clr_idx_d     = clr_idx_q;
    wr_conflict_d = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_idx_d = clr_idx_q + AW'(1);
        if (clr_idx_q == AW'(NREGS - 1)) state_d = READY;
      end
      READY: wr_conflict_d = collide;
      default: state_d = CLEAR;
    endcase
    if (reset) begin
      state_d       = CLEAR;
      clr_idx_d     = '0;
      wr_conflict_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    state_q       <= state_d;
    clr_idx_q     <= clr_idx_d;
    wr_conflict_q <= wr_conflict_d;
  end

  // Ascending port order makes the highest-numbered port win on a collision.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == CLEAR) mem[clr_idx_q] <= '0;
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j]) mem[waddr_w[j]] <= wdata_w[j];
      end
    end
  end

  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rd;
    assign ra = bus.raddr[gi*AW +: AW];

    always_comb begin
      rd = '0;
      if ((state_q == READY) && !((ZERO_REG != 0) && (ra == '0))) rd = mem[ra];
`ifdef REGFILE_BYPASS_EN
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && (waddr_w[j] == ra)) rd = wdata_w[j];
      end
`endif
    end

    assign bus.rdata[gi*XLEN +: XLEN] = rd;
  end

  assign bus.busy        = (state_q == CLEAR);
  assign bus.wr_conflict = wr_conflict_q;
endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp: dual-write instance (ZERO_REG=1) and a
// single-write instance (ZERO_REG=0) sharing clock and reset; expectations flow through a queue.
module tb_regfile_mp;
  logic clk;
  logic reset;

  regfile_mp_if #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2)) bus_a ();
  regfile_mp_if #(.XLEN(32), .NREGS(32), .NRD(1), .NWR(1)) bus_b ();

  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .ZERO_REG(1)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(1), .NWR(1), .ZERO_REG(0)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_q [$];
  string       tag_q [$];

  task automatic push(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    logic [31:0] e;
    string       t;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL scoreboard_empty observed=0x%08h expected=<none>", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        fails++;
        $error("FAIL %s observed=0x%08h expected=0x%08h", t, obs, e);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ra(input int k, input logic [4:0] a);
    bus_a.raddr[k*5 +: 5] = a;
  endtask

  task automatic wr_a(input int j, input logic [4:0] a, input logic [31:0] d);
    bus_a.we[j]            = 1'b1;
    bus_a.waddr[j*5 +: 5]  = a;
    bus_a.wdata[j*32 +: 32] = d;
  endtask

  task automatic idle();
    bus_a.we = '0;
    bus_b.we = '0;
  endtask

  function automatic logic [31:0] rd_a(input int k);
    return bus_a.rdata[k*32 +: 32];
  endfunction

  // Counts edges until busy drops (reset must already be low); pokes writes that must be ignored.
  task automatic wait_clear(input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
      if (n == 1 || n == 20) begin
        set_ra(0, 5'd5);
        set_ra(1, 5'd31);
        #1;
        push({tag, "_rd0_busy"}, 32'h0);
        pop_check(rd_a(0));
        push({tag, "_rd1_busy"}, 32'h0);
        pop_check(rd_a(1));
      end
      if (n >= 4 && n <= 8) wr_a(0, 5'd2, 32'h0000_0BAD);
      else idle();
    end while (bus_a.busy && n < 200);
    idle();
    push({tag, "_clear_edges"}, 32'd32);
    pop_check(32'(n));
    push({tag, "_b_busy"}, 32'h0);
    pop_check({31'h0, bus_b.busy});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    bus_a.raddr = '0; bus_a.we = '0; bus_a.waddr = '0; bus_a.wdata = '0;
    bus_b.raddr = '0; bus_b.we = '0; bus_b.waddr = '0; bus_b.wdata = '0;

    // Reset state
    repeat (3) tick();
    push("rst_busy", 32'h1);        pop_check({31'h0, bus_a.busy});
    push("rst_conflict", 32'h0);    pop_check({31'h0, bus_a.wr_conflict});
    push("rst_rdata0", 32'h0);      pop_check(rd_a(0));
    push("rst_rdata1", 32'h0);      pop_check(rd_a(1));

    // Clear sequence and full zero sweep
    reset = 1'b0;
    wait_clear("init");
    for (int a = 0; a < 32; a++) begin
      set_ra(0, 5'(a));
      set_ra(1, 5'(31 - a));
      #1;
      push($sformatf("zero_p0_x%0d", a), 32'h0);      pop_check(rd_a(0));
      push($sformatf("zero_p1_x%0d", 31 - a), 32'h0); pop_check(rd_a(1));
      tick();
    end

    // Basic write/read
    wr_a(0, 5'd5, 32'hDEAD_BEEF);
    set_ra(0, 5'd5);
    push("wr_x5", 32'hDEAD_BEEF);
    tick(); idle(); #1;
    pop_check(rd_a(0));
    wr_a(1, 5'd31, 32'h1234_5678);
    set_ra(1, 5'd31);
    push("wr_x31", 32'h1234_5678);
    push("x5_kept", 32'hDEAD_BEEF);
    tick(); idle(); #1;
    pop_check(rd_a(1));
    pop_check(rd_a(0));

    // Zero register: dropped with ZERO_REG=1, stored with ZERO_REG=0
    wr_a(0, 5'd0, 32'hFFFF_FFFF);
    bus_b.we = 1'b1; bus_b.waddr = 5'd0; bus_b.wdata = 32'hFFFF_FFFF;
    set_ra(0, 5'd0);
    bus_b.raddr = 5'd0;
    push("zreg_x0", 32'h0);
    push("nozreg_x0", 32'hFFFF_FFFF);
    tick(); idle(); #1;
    pop_check(rd_a(0));
    pop_check(bus_b.rdata);

    // Non-colliding dual write
    wr_a(0, 5'd8, 32'h0000_00AA);
    wr_a(1, 5'd12, 32'h0000_00BB);
    set_ra(0, 5'd8);
    set_ra(1, 5'd12);
    push("dual_x8", 32'hAA);
    push("dual_x12", 32'hBB);
    push("dual_noconf", 32'h0);
    tick(); idle(); #1;
    pop_check(rd_a(0));
    pop_check(rd_a(1));
    pop_check({31'h0, bus_a.wr_conflict});

    // Collision on x7: port 1 wins, one-cycle flag
    wr_a(0, 5'd7, 32'h11);
    wr_a(1, 5'd7, 32'h22);
    set_ra(0, 5'd7);
    push("coll_x7", 32'h22);
    push("coll_flag", 32'h1);
    push("coll_flag_clr", 32'h0);
    tick(); idle(); #1;
    pop_check(rd_a(0));
    pop_check({31'h0, bus_a.wr_conflict});
    tick();
    pop_check({31'h0, bus_a.wr_conflict});

    // Collision on x0 still flags, entry stays zero
    wr_a(0, 5'd0, 32'h33);
    wr_a(1, 5'd0, 32'h44);
    set_ra(0, 5'd0);
    push("coll0_flag", 32'h1);
    push("coll0_x0", 32'h0);
    tick(); idle(); #1;
    pop_check({31'h0, bus_a.wr_conflict});
    pop_check(rd_a(0));

    // Same-cycle read of the address being written
    wr_a(0, 5'd9, 32'h0000_CAFE);
    set_ra(0, 5'd9);
    #1;
`ifdef REGFILE_BYPASS_EN
    push("bypass_x9", 32'h0000_CAFE);
`else
    push("bypass_x9", 32'h0);
`endif
    pop_check(rd_a(0));
    push("after_x9", 32'h0000_CAFE);
    tick(); idle(); #1;
    pop_check(rd_a(0));

    // Reset mid-clear at index 10 restarts a full clear
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (10) tick();
    reset = 1'b1;
    tick();
    push("midclr_busy", 32'h1);
    pop_check({31'h0, bus_a.busy});
    reset = 1'b0;
    wait_clear("midclr");

    // Reset mid-operation with a pending write to x3
    wr_a(0, 5'd5, 32'h5555_5555);
    push("pre_x5", 32'h5555_5555);
    tick(); idle(); #1;
    set_ra(0, 5'd5);
    #1;
    pop_check(rd_a(0));
    wr_a(0, 5'd3, 32'h0000_0333);
    reset = 1'b1;
    tick(); idle();
    reset = 1'b0;
    wait_clear("midop");
    set_ra(0, 5'd3);
    set_ra(1, 5'd5);
    #1;
    push("midop_x3", 32'h0);  pop_check(rd_a(0));
    push("midop_x5", 32'h0);  pop_check(rd_a(1));
    set_ra(0, 5'd2);
    #1;
    push("clear_wr_ignored_x2", 32'h0);  pop_check(rd_a(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
